adc_ltc2308_scan: RTL and testbench
===================================

// Module: adc_ltc2308_scan
// PURPOSE
//  Autonomous scan sequencer for the LTC2308 8-ch 12-bit SAR ADC on adc_convst/adc_sck/adc_sdi/adc_sdo.
//  Cycles through channels enabled in ch_mask and drives CONVST, SCK and the 6-bit SDI config word.
//  Deserialises SDO and emits one {channel, 12-bit sample} strobe per conversion toward a CSR/PIO layer.
//  Sits beside the debounce and PIO logic in the top level, on the 50 MHz fabric clock.
// PARAMETERS
//  CLK_DIV      2   clk cycles per SCK half-period (>=1); SCK = clk/(2*CLK_DIV)
//  CONV_CYCLES  80  clk cycles CONVST held high (tCONV; 1.6 us at 50 MHz), >=2
//  ACQ_CYCLES   13  clk cycles idle between last SCK fall and next CONVST rise (tACQ), >=1
// PORTS
//  clk          in   1   fabric clock (50 MHz)
//  reset_n      in   1   async active-low reset
//  enable       in   1   1 = scan continuously; 0 = stop after current frame
//  ch_mask      in   8   bit n set = channel n in scan
//  uni          in   1   1 = unipolar, 0 = bipolar (config UNI bit)
//  busy         out  1   1 whenever FSM is not IDLE
//  result_valid out  1   1-cycle strobe: result_ch/result_data valid
//  result_ch    out  3   channel of result_data
//  result_data  out  12  conversion result, MSB first off SDO
//  adc_convst   out  1   ADC CONVST
//  adc_sck      out  1   ADC SCK
//  adc_sdi      out  1   ADC SDI (config word)
//  adc_sdo      in   1   ADC SDO
// BEHAVIOUR
//  Reset (async): state IDLE; adc_convst, adc_sck, adc_sdi, busy, result_valid = 0; result_ch, result_data = 0;
//    primed = 0; next-channel pointer = 0. Reset mid-frame aborts at once; no further SCK edges.
//  FSM: IDLE -> CONV -> SHIFT -> ACQ -> (CONV | IDLE).
//   IDLE: all ADC outputs 0. Go to CONV when enable=1 and ch_mask!=0; primed cleared on entry to IDLE.
//   CONV: adc_convst=1 for exactly CONV_CYCLES cycles, then SHIFT.
//   SHIFT: adc_convst=0; 12 SCK periods, 24*CLK_DIV cycles; SCK starts low, first rise CLK_DIV cycles in.
//    adc_sdi = cfg[5] on entry; updates to next cfg bit on each SCK fall; after cfg[0] (6th fall), sdi=0.
//    adc_sdo sampled on the clk edge that drives SCK 0->1; shifted into data reg MSB first.
//   ACQ: all ADC outputs 0 for ACQ_CYCLES cycles; then CONV if enable=1 and ch_mask!=0, else IDLE.
//  Config word (latched on SHIFT entry) for channel c: cfg = {1'b1, c[0], c[2], c[1], uni, 1'b0}
//    (single-ended, SLP=0).
//  Channel pick on SHIFT entry: lowest set mask bit at or above pointer, wrapping 7->0.
//    Pointer becomes pick+1 (mod 8). Mask/uni changes take effect at the next pick only.
//  Pipeline: the ADC converts using the config shifted in the PREVIOUS frame.
//    cur_ch := ch configured in previous frame; valid only if primed=1.
//  End of SHIFT (after 12th sample): if primed, result_valid=1 for 1 cycle with result_ch=cur_ch and
//    result_data=shift reg; set primed=1.
//    First frame after IDLE is a dummy: no strobe.
//  result_ch/result_data hold until the next strobe.
//  enable falling: current frame completes (incl. ACQ); no partial SCK burst ever.
//    The config shifted in the last frame is discarded.
//  Mask going 0 mid-frame: frame completes with the already-latched channel; then IDLE.
//  Single-channel mask: same channel every frame. Frame period = CONV_CYCLES + 24*CLK_DIV + ACQ_CYCLES
//    (141 cycles at defaults).
// TESTING
//  1 Reset: hold reset_n=0 with enable=1 -> all outputs 0; release with mask=0 -> busy stays 0.
//  2 mask=8'h01, uni=1, enable=1 -> frame 1 has no strobe. Frame 2: SDI = 6'b100010, strobe ch0,
//    data = model SDO word (e.g. 12'hA5C). Period = 141 clk.
//  3 mask=8'b1010_0100 -> SDI channel sequence 2,5,7,2,5. Strobed result_ch = 2,5,7,2 (one frame lag).
//  4 CONVST high width = 80 clk; 12 SCK rises per frame; SCK period = 4 clk; 13 clk from last SCK fall
//    to next CONVST rise.
//  5 Drop enable mid-SHIFT -> frame completes with its strobe; then IDLE, busy=0 after ACQ.
//    Re-enable -> dummy frame again (no strobe).
//  6 Assert reset_n=0 mid-SHIFT -> adc_sck/convst/sdi=0 in the same cycle; restart resumes at ch0 with
//    a dummy frame.

Source files
------------

// File: rtl/adc_ltc2308_scan.sv
// rtl/adc_ltc2308_scan.sv - LTC2308 autonomous channel scan sequencer
// Runs CONVST/SCK/SDI frames over the channels in ch_mask_i and strobes one sample per frame.
module adc_ltc2308_scan #(
   parameter int CLK_DIV     = 2,
   parameter int CONV_CYCLES = 80,
   parameter int ACQ_CYCLES  = 13
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        enable_i,
   input  logic [7:0]  ch_mask_i,
   input  logic        uni_i,
   output logic        busy_o,
   output logic        result_valid_o,
   output logic [2:0]  result_ch_o,
   output logic [11:0] result_data_o,
   output logic        adc_convst_o,
   output logic        adc_sck_o,
   output logic        adc_sdi_o,
   input  logic        adc_sdo_i
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CONV  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_ACQ   = 2'd3;

   localparam int CW = 16;
   localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
   localparam logic [CW-1:0] ACQ_LAST  = CW'(ACQ_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    half_q, half_d;
   logic [5:0]    cfg_q, cfg_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    cfg_ch_q, cfg_ch_d;
   logic [2:0]    prev_ch_q, prev_ch_d;
   logic          primed_q, primed_d;
   logic [11:0]   shreg_q, shreg_d;
   logic          valid_q, valid_d;
   logic [2:0]    res_ch_q, res_ch_d;
   logic [11:0]   res_data_q, res_data_d;
   logic          convst_q, sck_q, sdi_q, busy_q;
   logic [2:0]    pick;
   logic          scan_go;

   assign scan_go = enable_i && (ch_mask_i != 8'd0);

   // Walk downwards so the lowest set bit at/after the pointer wins.
   always_comb begin
      pick = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         if (ch_mask_i[ptr_q + 3'(i)]) pick = ptr_q + 3'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_d     = half_q;
      cfg_d      = cfg_q;
      ptr_d      = ptr_q;
      cfg_ch_d   = cfg_ch_q;
      prev_ch_d  = prev_ch_q;
      primed_d   = primed_q;
      shreg_d    = shreg_q;
      valid_d    = 1'b0;
      res_ch_d   = res_ch_q;
      res_data_d = res_data_q;
      case (state_q)
         S_IDLE: begin
            primed_d = 1'b0;
            if (scan_go) begin
               state_d = S_CONV;
               cnt_d   = '0;
            end
         end
         S_CONV: begin
            if (cnt_q == CONV_LAST) begin
               state_d   = S_SHIFT;
               cnt_d     = '0;
               half_d    = '0;
               cfg_d     = {1'b1, pick[0], pick[2], pick[1], uni_i, 1'b0};
               prev_ch_d = cfg_ch_q;
               cfg_ch_d  = pick;
               ptr_d     = pick + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               half_d = half_q + 5'd1;
               // Even half-period ends with SCK rising: sample SDO. Odd ends falling: next SDI bit.
               if (!half_q[0]) shreg_d = {shreg_q[10:0], adc_sdo_i};
               else            cfg_d   = {cfg_q[4:0], 1'b0};
               if (half_q == 5'd23) begin
                  state_d  = S_ACQ;
                  half_d   = '0;
                  valid_d  = primed_q;
                  primed_d = 1'b1;
                  if (primed_q) begin
                     res_ch_d   = prev_ch_q;
                     res_data_d = shreg_q;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (cnt_q == ACQ_LAST) begin
               cnt_d = '0;
               if (scan_go) begin
                  state_d = S_CONV;
               end else begin
                  state_d  = S_IDLE;
                  primed_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         half_q     <= '0;
         cfg_q      <= '0;
         ptr_q      <= '0;
         cfg_ch_q   <= '0;
         prev_ch_q  <= '0;
         primed_q   <= 1'b0;
         shreg_q    <= '0;
         valid_q    <= 1'b0;
         res_ch_q   <= '0;
         res_data_q <= '0;
         convst_q   <= 1'b0;
         sck_q      <= 1'b0;
         sdi_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         cfg_q      <= cfg_d;
         ptr_q      <= ptr_d;
         cfg_ch_q   <= cfg_ch_d;
         prev_ch_q  <= prev_ch_d;
         primed_q   <= primed_d;
         shreg_q    <= shreg_d;
         valid_q    <= valid_d;
         res_ch_q   <= res_ch_d;
         res_data_q <= res_data_d;
         convst_q   <= (state_d == S_CONV);
         sck_q      <= (state_d == S_SHIFT) && half_d[0];
         sdi_q      <= (state_d == S_SHIFT) && cfg_d[5];
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign busy_o         = busy_q;
   assign result_valid_o = valid_q;
   assign result_ch_o    = res_ch_q;
   assign result_data_o  = res_data_q;
   assign adc_convst_o   = convst_q;
   assign adc_sck_o      = sck_q;
   assign adc_sdi_o      = sdi_q;
endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// tb/tb_adc_ltc2308_scan.sv - self-checking bench for adc_ltc2308_scan
// Behavioural LTC2308 model plus scan-order reference; table, random and corner-case runs.
module tb_adc_ltc2308_scan;
   localparam int DIV    = 2;
   localparam int CONV   = 80;
   localparam int ACQ    = 13;
   localparam int PERIOD = CONV + 24 * DIV + ACQ;

   logic        clk, reset_n, enable, uni, adc_sdo;
   logic [7:0]  ch_mask;
   logic        busy, result_valid, adc_convst, adc_sck, adc_sdi;
   logic [2:0]  result_ch;
   logic [11:0] result_data;

   adc_ltc2308_scan #(.CLK_DIV(DIV), .CONV_CYCLES(CONV), .ACQ_CYCLES(ACQ)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .ch_mask_i(ch_mask), .uni_i(uni),
      .busy_o(busy), .result_valid_o(result_valid), .result_ch_o(result_ch),
      .result_data_o(result_data), .adc_convst_o(adc_convst), .adc_sck_o(adc_sck),
      .adc_sdi_o(adc_sdi), .adc_sdo_i(adc_sdo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [5:0]  cfg;
      logic [11:0] word;
      int conv_w, rises, start, last_fall, r1, r2;
   } frame_t;
   typedef struct {
      logic [2:0]  ch;
      logic [11:0] data;
   } strobe_t;
   typedef struct {
      logic [7:0] mask;
      logic       uni;
      int         n;
      int         ch[5];
   } vec_t;

   frame_t  frames[$];
   strobe_t strobes[$];
   int      exp_q[$];
   frame_t  cur;
   int      cyc, n_starts, busy_fall, fr0, st0, m_ptr;
   int      n_tests, n_fail;
   logic    in_frame, prev_convst, prev_sck, prev_busy;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ADC model and observer: one record per CONVST frame, SDO shifted MSB first per SCK rise.
   initial begin
      strobe_t s;
      in_frame = 1'b0; prev_convst = 1'b0; prev_sck = 1'b0; prev_busy = 1'b0;
      adc_sdo = 1'b0; n_starts = 0; busy_fall = 0;
      cur = '{default: 0};
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_frame = 1'b0; prev_convst = 1'b0; prev_sck = 1'b0; prev_busy = 1'b0;
            adc_sdo = 1'b0;
         end else begin
            if (adc_convst && !prev_convst) begin
               if (in_frame) frames.push_back(cur);
               cur = '{default: 0};
               cur.word  = 12'($urandom);
               cur.start = cyc;
               in_frame  = 1'b1;
               n_starts++;
            end
            if (in_frame && adc_convst) cur.conv_w++;
            if (in_frame && adc_sck && !prev_sck) begin
               if (cur.rises < 6) cur.cfg = {cur.cfg[4:0], adc_sdi};
               if (cur.rises == 0) cur.r1 = cyc;
               if (cur.rises == 1) cur.r2 = cyc;
               cur.rises++;
            end
            if (in_frame && !adc_sck && prev_sck) cur.last_fall = cyc;
            if (!busy && prev_busy) begin
               busy_fall = cyc;
               if (in_frame) frames.push_back(cur);
               in_frame = 1'b0;
            end
            if (result_valid) begin
               s.ch = result_ch;
               s.data = result_data;
               strobes.push_back(s);
            end
            adc_sdo = (in_frame && cur.rises < 12) ? cur.word[11 - cur.rises] : 1'b0;
            prev_convst = adc_convst; prev_sck = adc_sck; prev_busy = busy;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   function automatic int pick(input logic [7:0] m, input int p);
      for (int k = 0; k < 8; k++) if (m[(p + k) % 8]) return (p + k) % 8;
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      enable  = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      m_ptr   = 0;
   endtask

   // Run n frames from IDLE; enable drops in the middle of the last frame's SHIFT.
   task automatic run(input logic [7:0] m, input logic u, input int n);
      int target, t;
      ch_mask = m; uni = u;
      fr0 = frames.size(); st0 = strobes.size();
      target = n_starts + n;
      enable = 1'b1;
      t = 0;
      while (n_starts < target && t < PERIOD * n + 400) begin
         @(negedge clk);
         t++;
      end
      chk("frames_started", n_starts, target);
      repeat (CONV + 20) @(negedge clk);
      enable = 1'b0;
      t = 0;
      while (busy && t < 2 * PERIOD) begin
         @(negedge clk);
         t++;
      end
      chk("busy_drops", busy, 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic check_run(input logic u, input int n);
      int nf, ns;
      logic [2:0] c;
      frame_t f, fp;
      nf = frames.size() - fr0;
      ns = strobes.size() - st0;
      chk("frame_count", nf, n);
      chk("strobe_count", ns, n - 1);
      for (int k = 0; k < nf && k < n; k++) begin
         f = frames[fr0 + k];
         c = 3'(exp_q[k]);
         chk("sdi_cfg", f.cfg, {1'b1, c[0], c[2], c[1], u, 1'b0});
         chk("convst_width", f.conv_w, CONV);
         chk("sck_rises", f.rises, 12);
         chk("sck_period", f.r2 - f.r1, 2 * DIV);
         if (k > 0) begin
            fp = frames[fr0 + k - 1];
            chk("frame_period", f.start - fp.start, PERIOD);
            chk("acq_gap", f.start - fp.last_fall, ACQ);
         end
      end
      for (int k = 0; k < ns && k < n - 1 && k + 1 < nf; k++) begin
         chk("strobe_ch", strobes[st0 + k].ch, exp_q[k]);
         chk("strobe_data", strobes[st0 + k].data, frames[fr0 + k + 1].word);
      end
      if (nf == n) begin
         chk("idle_after_acq", busy_fall - frames[fr0 + n - 1].start, PERIOD);
         chk("hold_ch", result_ch, exp_q[n - 2]);
         chk("hold_data", result_data, frames[fr0 + n - 1].word);
      end
   endtask

   initial begin
      vec_t vecs[5];
      int t, c, n;
      logic [7:0] m;
      logic u;
      n_tests = 0; n_fail = 0;
      vecs[0] = '{8'h01, 1'b1, 3, '{0, 0, 0, 0, 0}};
      vecs[1] = '{8'hA4, 1'b0, 5, '{2, 5, 7, 2, 5}};
      vecs[2] = '{8'h80, 1'b1, 3, '{7, 7, 7, 0, 0}};
      vecs[3] = '{8'h81, 1'b0, 4, '{0, 7, 0, 7, 0}};
      vecs[4] = '{8'h06, 1'b1, 4, '{1, 2, 1, 2, 0}};

      reset_n = 1'b0; enable = 1'b1; ch_mask = 8'hFF; uni = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {busy, result_valid, result_ch, result_data, adc_convst, adc_sck, adc_sdi}, 0);
      ch_mask = 8'h00;
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("mask0_busy", busy, 0);
      chk("mask0_no_frames", n_starts, 0);
      enable = 1'b0;

      foreach (vecs[i]) begin
         do_reset();
         exp_q.delete();
         for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].ch[k]);
         run(vecs[i].mask, vecs[i].uni, vecs[i].n);
         check_run(vecs[i].uni, vecs[i].n);
      end

      do_reset();
      for (int r = 0; r < 6; r++) begin
         m = 8'($urandom_range(1, 255));
         u = 1'($urandom_range(0, 1));
         n = $urandom_range(2, 4);
         exp_q.delete();
         for (int k = 0; k < n; k++) begin
            c = pick(m, m_ptr);
            exp_q.push_back(c);
            m_ptr = (c + 1) % 8;
         end
         run(m, u, n);
         check_run(u, n);
      end

      // Asynchronous reset in the middle of the second frame's SCK burst.
      do_reset();
      ch_mask = 8'h03; uni = 1'b0;
      t = n_starts + 2;
      enable = 1'b1;
      for (int w = 0; w < 3 * PERIOD && n_starts < t; w++) @(negedge clk);
      chk("second_frame_started", n_starts, t);
      repeat (CONV + 10) @(negedge clk);
      chk("sck_high_before_reset", adc_sck, 1);
      #2 reset_n = 1'b0;
      #1 chk("async_reset_outputs", {adc_sck, adc_convst, adc_sdi, busy, result_valid}, 0);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      m_ptr = 0;
      exp_q.delete();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      run(8'h03, 1'b0, 3);
      check_run(1'b0, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
